// File: rtl/spi_eng_pkg.sv
// Shared types and helpers for the SPI master shift engine.
package spi_eng_pkg;

  localparam int DW_DEF    = 32;
  localparam int LEN_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

  // Zero and oversize lengths both mean a full-width character.
  function automatic int eff_len(input int char_len, input int dw);
    return (char_len == 0 || char_len > dw) ? dw : char_len;
  endfunction

endpackage

// File: rtl/spi_bit_idx.sv
// Remaining-bit down-counter plus the bit index it implies for the current
// bit order; one instance serves the tx path, another the rx path.
module spi_bit_idx
  import spi_eng_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int IW    = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             dec_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             lsb_i,
  output logic [LEN_W-1:0] rem_o,
  output logic [IW-1:0]    idx_o
);

  logic [LEN_W-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (load_i) begin
      rem_d = load_val_i;
    end else if (dec_i && rem_q != '0) begin
      rem_d = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem_o = rem_q;
  // LSB-first walks upward from bit 0; MSB-first walks downward to bit 0.
  assign idx_o = lsb_i ? IW'(len_i - rem_q) : IW'(rem_q - LEN_W'(1));

endmodule

// File: rtl/spi_shift_eng.sv
// SPI master shift engine driven by the clock generator's edge pulses.
// Optional SPI_SHIFT_LOOPBACK_EN adds a loopback input routing mosi into rx.
module spi_shift_eng
  import spi_eng_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             go,
  input  logic [LEN_W-1:0] char_len,
  input  logic             lsb,
  input  logic             tx_negedge,
  input  logic             rx_negedge,
  input  logic [DW-1:0]    tx_data,
  input  logic             pos_edge,
  input  logic             neg_edge,
  input  logic             miso,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic             loopback,
`endif
  output logic             mosi,
  output logic             sclk_en,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    rx_data
);

  localparam int IW = $clog2(DW);

  state_e           state_q;
  logic             mosi_q, busy_q, done_q;
  logic             lsb_q, txn_q, rxn_q;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DW-1:0]    tx_sr_q, rx_sr_q, rx_sr_d, rx_data_q;
  logic [LEN_W-1:0] tx_rem, rx_rem;
  logic [IW-1:0]    tx_idx, rx_idx, first_idx;
  logic             accept, tx_ev, rx_ev, tx_fire, rx_fire, rx_bit;

  assign len_d     = LEN_W'(eff_len(int'(char_len), DW));
  assign accept    = (state_q == IDLE) && go;
  assign first_idx = lsb ? '0 : IW'(len_d - LEN_W'(1));
  assign tx_ev     = txn_q ? neg_edge : pos_edge;
  assign rx_ev     = rxn_q ? neg_edge : pos_edge;
  assign tx_fire   = (state_q == SHIFT) && tx_ev && (tx_rem != '0);
  assign rx_fire   = (state_q == SHIFT) && rx_ev && (rx_rem != '0);

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_q : miso;
`else
  assign rx_bit = miso;
`endif

  always_comb begin
    rx_sr_d         = rx_sr_q;
    rx_sr_d[rx_idx] = rx_bit;
  end

  // The first bit is presented at go, so tx only counts the L-1 advances.
  spi_bit_idx #(.LEN_W(LEN_W), .IW(IW)) u_tx_idx (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (len_d - LEN_W'(1)),
    .dec_i      (tx_fire),
    .len_i      (len_q),
    .lsb_i      (lsb_q),
    .rem_o      (tx_rem),
    .idx_o      (tx_idx)
  );

  spi_bit_idx #(.LEN_W(LEN_W), .IW(IW)) u_rx_idx (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (len_d),
    .dec_i      (rx_fire),
    .len_i      (len_q),
    .lsb_i      (lsb_q),
    .rem_o      (rx_rem),
    .idx_o      (rx_idx)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      len_q     <= '0;
      lsb_q     <= 1'b0;
      txn_q     <= 1'b0;
      rxn_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            tx_sr_q <= tx_data;
            len_q   <= len_d;
            lsb_q   <= lsb;
            txn_q   <= tx_negedge;
            rxn_q   <= rx_negedge;
            mosi_q  <= tx_data[first_idx];
            rx_sr_q <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (tx_fire) begin
            mosi_q <= tx_sr_q[tx_idx];
          end
          if (rx_fire) begin
            rx_sr_q <= rx_sr_d;
            // Last sample lands directly in rx_data so done and data align.
            if (rx_rem == LEN_W'(1)) begin
              rx_data_q <= rx_sr_d;
              done_q    <= 1'b1;
              state_q   <= FIN;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign sclk_en = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule
